// File: rtl/fc_weight_stream_ctrl_pkg.sv
// rtl/fc_weight_stream_ctrl_pkg.sv - shared FSM state type and output FIFO sizing for the weight streamer
package fc_weight_stream_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One slot per read that can be in the ROM pipe, plus one so a full pipe never stalls the stream.
    function automatic int fifo_depth(input int rom_latency);
        return rom_latency + 1;
    endfunction

endpackage

// File: rtl/fc_weight_stream_ctrl_if.sv
// rtl/fc_weight_stream_ctrl_if.sv - valid/ready weight stream bundle (data_out_last present with WEIGHT_STREAM_LAST_EN)
interface fc_weight_stream_ctrl_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_out_valid;
    logic                  data_out_ready;
`ifdef WEIGHT_STREAM_LAST_EN
    logic                  data_out_last;
`endif

    modport master (
        output data_out,
        output data_out_valid,
`ifdef WEIGHT_STREAM_LAST_EN
        output data_out_last,
`endif
        input  data_out_ready
    );

    modport slave (
        input  data_out,
        input  data_out_valid,
`ifdef WEIGHT_STREAM_LAST_EN
        input  data_out_last,
`endif
        output data_out_ready
    );
endinterface

// File: rtl/weight_stream_fifo.sv
// rtl/weight_stream_fifo.sv - small synchronous FIFO buffering ROM words ahead of the output stream
module weight_stream_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic                           rd_en,
    output logic [WIDTH-1:0]               rd_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_rd) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/fc_weight_stream_ctrl.sv
// rtl/fc_weight_stream_ctrl.sv - sweeps a weight ROM num_passes times into a valid/ready stream; WEIGHT_STREAM_LAST_EN adds data_out_last
module fc_weight_stream_ctrl
    import fc_weight_stream_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH       = 32,
    parameter int ROM_LATENCY = 2,
    parameter int PASS_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [PASS_WIDTH-1:0]        num_passes,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(DEPTH+1)-1:0]   rom_addr,
    output logic                         rom_ce,
    input  logic [DATA_WIDTH-1:0]        rom_q,
    fc_weight_stream_ctrl_if.master      stream
);
    localparam int AW         = $clog2(DEPTH+1);
    localparam int FIFO_DEPTH = fifo_depth(ROM_LATENCY);
    localparam int CW         = $clog2(FIFO_DEPTH+1);
`ifdef WEIGHT_STREAM_LAST_EN
    localparam int FW = DATA_WIDTH + 1;
`else
    localparam int FW = DATA_WIDTH;
`endif

    state_t                  state;
    state_t                  state_next;
    logic [PASS_WIDTH-1:0]   passes_q;
    logic [PASS_WIDTH-1:0]   pass_cnt;
    logic [ROM_LATENCY-1:0]  tags;
    logic [CW-1:0]           inflight;
    logic [CW-1:0]           fifo_count;
    logic [CW:0]             outstanding;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [FW-1:0]           fifo_wr_data;
    logic [FW-1:0]           fifo_rd_data;
    logic                    pop;
    logic                    issue;
    logic                    issue_ok;
    logic                    last_addr;
    logic                    last_pass;
    logic                    final_beat;
    logic                    launch;
    logic                    done_next;

    assign busy      = (state != IDLE);
    assign launch    = (state == IDLE) && start && (num_passes != '0);
    assign last_addr = (rom_addr == AW'(DEPTH-1));
    assign last_pass = (pass_cnt == passes_q - PASS_WIDTH'(1));

    assign stream.data_out_valid = !fifo_empty;
    assign stream.data_out       = fifo_rd_data[DATA_WIDTH-1:0];
    assign pop                   = stream.data_out_valid && stream.data_out_ready;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_LATENCY; i++) begin
            inflight = inflight + CW'(tags[i]);
        end
    end

    // A word leaving the FIFO this cycle frees its slot for a read issued in the same cycle.
    assign outstanding = {1'b0, inflight} + {1'b0, fifo_count} - (CW+1)'(pop);
    assign issue_ok    = !fifo_full && (outstanding < (CW+1)'(FIFO_DEPTH));
    assign final_beat  = pop && (inflight == '0) && (fifo_count == CW'(1));

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (num_passes != '0) state_next = ISSUE;
                    else                  done_next  = 1'b1;
                end
            end
            ISSUE: begin
                issue = issue_ok;
                if (issue && last_addr && last_pass) state_next = DRAIN;
            end
            DRAIN: begin
                if (final_beat) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            done     <= 1'b0;
            rom_ce   <= 1'b0;
            rom_addr <= '0;
            passes_q <= '0;
            pass_cnt <= '0;
            tags     <= '0;
        end else begin
            state  <= state_next;
            done   <= done_next;
            rom_ce <= 1'b1;
            tags   <= (tags << 1) | ROM_LATENCY'(issue);
            if (launch) begin
                passes_q <= num_passes;
                pass_cnt <= '0;
                rom_addr <= '0;
            end else if (issue) begin
                if (last_addr) begin
                    rom_addr <= '0;
                    pass_cnt <= pass_cnt + PASS_WIDTH'(1);
                end else begin
                    rom_addr <= rom_addr + AW'(1);
                end
            end
        end
    end

`ifdef WEIGHT_STREAM_LAST_EN
    // The last-of-pass flag rides the same latency pipe as its read so it lands beside its word.
    logic [ROM_LATENCY-1:0] last_tags;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_tags <= '0;
        else     last_tags <= (last_tags << 1) | ROM_LATENCY'(issue && last_addr);
    end

    assign fifo_wr_data         = {last_tags[ROM_LATENCY-1], rom_q};
    assign stream.data_out_last = fifo_rd_data[DATA_WIDTH];
`else
    assign fifo_wr_data = rom_q;
`endif

    weight_stream_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tags[ROM_LATENCY-1]),
        .wr_data (fifo_wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );
endmodule

// File: tb/tb_fc_weight_stream_ctrl.sv
// tb/tb_fc_weight_stream_ctrl.sv - scoreboard bench for fc_weight_stream_ctrl (DEPTH=4, ROM_LATENCY=2)
module tb_fc_weight_stream_ctrl;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;
    localparam int PW    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [PW-1:0] num_passes = '0;
    logic          busy;
    logic          done;
    logic [2:0]    rom_addr;
    logic          rom_ce;
    logic [DW-1:0] rom_q;

    fc_weight_stream_ctrl_if #(.DATA_WIDTH(DW)) sif ();

    fc_weight_stream_ctrl #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .ROM_LATENCY (LAT),
        .PASS_WIDTH  (PW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_passes (num_passes),
        .busy       (busy),
        .done       (done),
        .rom_addr   (rom_addr),
        .rom_ce     (rom_ce),
        .rom_q      (rom_q),
        .stream     (sif.master)
    );

    always #5 clk = ~clk;

    // ROM model: word for the address presented in cycle c appears on rom_q in cycle c+LAT
    logic [DW-1:0] rom_mem [8];
    logic [DW-1:0] rom_p0, rom_p1;
    always @(posedge clk) begin
        rom_p0 <= rom_mem[rom_addr];
        rom_p1 <= rom_p0;
    end
    assign rom_q = rom_p1;

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [DW:0] exp_q [$];
    logic [DW:0] e;
    int  cyc = 0;
    int  beat_cnt, done_cnt, busy_cnt, first_beat_cyc, last_beat_cyc, done_cyc, lat;
    bit  ready_rand = 1'b0;
    bit  held = 1'b0;
    logic [DW-1:0] held_data;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        sif.data_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            sif.data_out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (held) begin
                check("stall_valid", sif.data_out_valid, 1);
                check("stall_data", sif.data_out, held_data);
            end
            held      = sif.data_out_valid && !sif.data_out_ready;
            held_data = sif.data_out;
            check("fifo_occ_le3", dut.u_fifo.count <= 3, 1);
            if (sif.data_out_valid && sif.data_out_ready) begin
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("beat_data", sif.data_out, e[DW-1:0]);
`ifdef WEIGHT_STREAM_LAST_EN
                    check("beat_last", sif.data_out_last, e[DW]);
`endif
                end
                beat_cnt++;
                if (beat_cnt == 1) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_low_at_done", busy, 0);
            end
            if (busy) busy_cnt++;
        end else begin
            held = 1'b0;
        end
    end

    // Launch a sequence from idle, queue its expected beats and measure first-valid latency.
    task automatic run_seq(input int n);
        beat_cnt = 0; done_cnt = 0; busy_cnt = 0; first_beat_cyc = -1;
        for (int p = 0; p < n; p++)
            for (int a = 0; a < DEPTH; a++)
                exp_q.push_back({(a == DEPTH-1), rom_mem[a]});
        @(posedge clk); #1;
        start = 1'b1; num_passes = PW'(n);
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!sif.data_out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (busy && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", busy, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rom_mem[i] = DW'(16'h3C00 + i * 16'h0111);
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", sif.data_out_valid, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_ce", rom_ce, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ce_after_rst", rom_ce, 1);

        // single pass, latency, done timing
        run_seq(1);
        check("t1_latency", lat, LAT + 2);
        wait_idle(200);
        check("t1_beats", beat_cnt, 4);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_done_cyc", done_cyc, last_beat_cyc + 1);
        check("t1_q_empty", exp_q.size(), 0);

        // three passes, no bubbles across wrap
        run_seq(3);
        check("t2_latency", lat, LAT + 2);
        wait_idle(200);
        check("t2_beats", beat_cnt, 12);
        check("t2_no_bubble", last_beat_cyc - first_beat_cyc, 11);
        check("t2_done_cnt", done_cnt, 1);
        check("t2_done_cyc", done_cyc, last_beat_cyc + 1);
        check("t2_q_empty", exp_q.size(), 0);

        // random backpressure
        ready_rand = 1'b1;
        run_seq(5);
        wait_idle(2000);
        check("t3_beats", beat_cnt, 20);
        check("t3_done_cnt", done_cnt, 1);
        check("t3_q_empty", exp_q.size(), 0);
        ready_rand = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // zero passes
        beat_cnt = 0; done_cnt = 0; busy_cnt = 0;
        start = 1'b1; num_passes = '0;
        @(posedge clk); #1;
        start = 1'b0;
        check("t4_done_next", done, 1);
        check("t4_busy", busy, 0);
        repeat (5) @(posedge clk);
        #1;
        check("t4_beats", beat_cnt, 0);
        check("t4_busy_cycles", busy_cnt, 0);
        check("t4_done_cnt", done_cnt, 1);

        // reset after beat 2, then a clean run
        run_seq(1);
        lat = 0;
        while (beat_cnt < 2 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("t5_reached_beat2", beat_cnt >= 2, 1);
        #1 rst = 1'b1;
        exp_q.delete();
        done_cnt = 0;
        #1;
        check("t5_rst_valid", sif.data_out_valid, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_addr", rom_addr, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("t5_no_done_abort", done_cnt, 0);
        run_seq(1);
        wait_idle(200);
        check("t5_beats", beat_cnt, 4);
        check("t5_done_cnt", done_cnt, 1);
        check("t5_q_empty", exp_q.size(), 0);

        // start re-pulsed while busy
        run_seq(2);
        start = 1'b1; num_passes = PW'(5);
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(300);
        check("t6_beats", beat_cnt, 8);
        check("t6_done_cnt", done_cnt, 1);
        check("t6_q_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/fc_weight_stream_ctrl.md
FC_WEIGHT_STREAM_CTRL -- requirements
Module: fc_weight_stream_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, meaning the width of one ROM word and one output beat.
REQ-002 The block SHALL have parameter DEPTH, default 32, meaning the number of ROM words per pass.
REQ-003 The block SHALL have parameter ROM_LATENCY, default 2, meaning the fixed cycles from rom_addr issue to rom_q valid.
REQ-004 The block SHALL have parameter PASS_WIDTH, default 8, meaning the width of num_passes.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port start, input, 1 bit: pulse that launches a sequence.
REQ-008 The block SHALL have port num_passes, input, PASS_WIDTH bits: full ROM sweeps per sequence, sampled with start.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a sequence is active.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse at sequence end.
REQ-011 The block SHALL have port rom_addr, output, $clog2(DEPTH+1) bits: ROM read address.
REQ-012 The block SHALL have port rom_ce, output, 1 bit: ROM enable, held at 1 when out of reset.
REQ-013 The block SHALL have port rom_q, input, DATA_WIDTH bits: ROM read data.
REQ-014 The block SHALL have ports data_out (output, DATA_WIDTH bits), data_out_valid (output, 1 bit) and data_out_ready (input, 1 bit): the valid/ready weight stream.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE and DRAIN; transitions: IDLE->ISSUE on start with num_passes!=0; ISSUE->DRAIN after the final address of the final pass; DRAIN->IDLE when the final beat is accepted.
REQ-016 start with num_passes==0 SHALL pulse done on the next cycle, emit no beats and leave busy low.
REQ-017 start while busy SHALL be ignored.
REQ-018 A read SHALL issue in ISSUE only when in-flight reads plus FIFO occupancy is less than FIFO_DEPTH = ROM_LATENCY+1, so no returned word is ever dropped.
REQ-019 A ROM_LATENCY-bit valid shift register SHALL tag each issued read, and rom_q SHALL be written to the FIFO when the tag emerges.
REQ-020 rom_addr SHALL advance 0..DEPTH-1, wrap to 0 and increment the pass counter; the final address issued SHALL be DEPTH-1 of pass num_passes-1.
REQ-021 data_out_valid SHALL equal FIFO non-empty, and a beat SHALL transfer only when data_out_valid and data_out_ready are both high.
REQ-022 data_out and data_out_valid SHALL stay stable while valid is high and ready is low.
REQ-023 The first data_out_valid SHALL assert exactly ROM_LATENCY+2 cycles after the edge that samples start, provided no prior backpressure.
REQ-024 With data_out_ready held high, throughput SHALL be one beat per cycle with no bubbles, including across pass wrap.
REQ-025 done SHALL pulse in the cycle after the final beat transfer, and busy SHALL fall in that same cycle.

Reset
REQ-026 Asserting rst SHALL force state IDLE, all counters, tags and FIFO pointers to 0, busy=0, done=0, data_out_valid=0, rom_addr=0 and rom_ce=0, regardless of clk.
REQ-027 rst mid-sequence SHALL abort the sequence with no done pulse, and the next start SHALL begin at address 0.

Configuration
REQ-028 With macro WEIGHT_STREAM_LAST_EN defined, the block SHALL add output port data_out_last (1 bit), high with the beat carrying address DEPTH-1 of every pass and low otherwise; the flag SHALL be stored in the FIFO alongside data.
REQ-029 Without WEIGHT_STREAM_LAST_EN, the data_out_last port and its FIFO bit SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (IDLE/ISSUE/DRAIN) and the FIFO_DEPTH derivation function.
REQ-031 The output buffer SHALL be a sub-module, weight_stream_fifo (synchronous, FIFO_DEPTH entries, full and empty flags).

Verification
REQ-032 DEPTH=4, num_passes=1, ready=1: data_out SHALL be ROM[0..3] on consecutive cycles, the first beat SHALL arrive 4 cycles after start, and done SHALL pulse once.
REQ-033 DEPTH=4, num_passes=3, ready=1: the bench SHALL see 12 beats with no bubble, addresses 0,1,2,3,0,...,3; with the macro, last SHALL be high on beats 4, 8 and 12.
REQ-034 ready toggling 1,0,0,1,... at random: the bench SHALL see no lost or duplicated word, stable data while stalled, and FIFO occupancy never above 3.
REQ-035 start with num_passes=0: the bench SHALL see done on the next cycle, zero beats and busy never high.
REQ-036 rst asserted after beat 2 of a 4-word pass, then start with num_passes=1: no done pulse SHALL occur for the aborted run, and the new run SHALL output ROM[0..3].
REQ-037 start re-pulsed mid-sequence: it SHALL be ignored, the beat count SHALL be unchanged and exactly one done pulse SHALL occur.
